// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, DW-bit dividend by VW-bit divisor.
// Resolves one quotient bit per clock behind a start/ready/done handshake.
// Results and the divide-by-zero flag are registered and held until the
// next accepted operation reaches DONE (div_by_zero clears at acceptance).
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // Iteration counter only needs to reach DW-1; the last step is detected
    // by comparison rather than by overflow.
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // One restoring step. The trial value is VW+1 bits wide ({R, next MSB});
    // the returned remainder is only VW bits because after a successful
    // subtract it is below the divisor, and after a failed one the trial was
    // already below the divisor, so the top bit is always zero.
    // Returns {new_remainder, quotient_bit}.
    function automatic logic [VW:0] restore_step(
        input logic [VW-1:0] r,
        input logic [VW-1:0] d,
        input logic          msb
    );
        logic [VW:0] t;
        t = {r, msb};
        if (t >= {1'b0, d}) begin
            restore_step = {t[VW-1:0] - d, 1'b1};
        end else begin
            restore_step = {t[VW-1:0], 1'b0};
        end
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;

    logic [DW-1:0] dq_r;        // dividend shifting out / quotient shifting in
    logic [VW-1:0] d_r;         // captured divisor
    logic [VW-1:0] r_r;         // partial remainder
    logic [CW-1:0] cnt_r;       // completed RUN steps

    logic [DW-1:0] quotient_r;
    logic [VW-1:0] remainder_r;
    logic          dbz_r;

    logic          accept_s;
    logic          zero_div_s;
    logic          last_s;
    logic [VW:0]   step_s;
    logic [VW-1:0] r_step_s;
    logic [DW-1:0] dq_step_s;

    // Handshake decode and the combinational restoring step.
    always_comb begin
        accept_s   = 1'b0;
        zero_div_s = 1'b0;
        last_s     = 1'b0;
        step_s     = {(VW+1){1'b0}};
        r_step_s   = {VW{1'b0}};
        dq_step_s  = {DW{1'b0}};

        accept_s   = (state_r == ST_IDLE) && start;
        zero_div_s = (divisor == {VW{1'b0}});
        last_s     = (cnt_r == CW'(DW - 1));
        step_s     = restore_step(r_r, d_r, dq_r[DW-1]);
        r_step_s   = step_s[VW:1];
        dq_step_s  = {dq_r[DW-2:0], step_s[0]};
    end

    // Next-state logic: IDLE -> RUN (or straight to DONE on a zero divisor),
    // RUN for DW steps, DONE for exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (zero_div_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Working registers: capture operands on acceptance, step during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_r  <= {DW{1'b0}};
            d_r   <= {VW{1'b0}};
            r_r   <= {VW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            dq_r  <= dividend;
            d_r   <= divisor;
            r_r   <= {VW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_RUN) begin
            dq_r  <= dq_step_s;
            r_r   <= r_step_s;
            cnt_r <= cnt_r + CW'(1);
        end else begin
            dq_r  <= dq_r;
            d_r   <= d_r;
            r_r   <= r_r;
            cnt_r <= cnt_r;
        end
    end

    // Result registers: loaded on the edge that enters DONE so the values
    // are already valid in the cycle where done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {VW{1'b0}};
            dbz_r       <= 1'b0;
        end else if (accept_s) begin
            if (zero_div_s) begin
                quotient_r  <= {DW{1'b1}};
                remainder_r <= dividend[VW-1:0];
                dbz_r       <= 1'b1;
            end else begin
                dbz_r       <= 1'b0;
            end
        end else if ((state_r == ST_RUN) && last_s) begin
            quotient_r  <= dq_step_s;
            remainder_r <= r_step_s;
        end else begin
            quotient_r  <= quotient_r;
            remainder_r <= remainder_r;
            dbz_r       <= dbz_r;
        end
    end

    assign ready       = (state_r == ST_IDLE);
    assign busy        = (state_r == ST_RUN);
    assign done        = (state_r == ST_DONE);
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed sequence plus exhaustive sweep for seq_divider.
// Expected results are pushed to a scoreboard queue when an operation is
// launched and popped when done is observed.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;   // edges after the accepting edge until done is visible
    } exp_t;

    exp_t       sb[$];
    int         checks;
    int         errors;
    int         cyc;
    logic [7:0] prev_q;
    logic [3:0] prev_r;

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for ready, present an operation for one cycle, push its expectation.
    task automatic launch(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] q, input logic [3:0] r,
                          input logic z, input int lat);
        exp_t e;
        int   w;
        w = 0;
        while (ready !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready_before_start", 32'(ready), 32'(1));
        e.a = a; e.b = b; e.q = q; e.r = r; e.z = z; e.lat = lat;
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        check("ready_low_after_accept", 32'(ready), 32'(0));
        check("busy_after_accept", 32'(busy), 32'(lat > 0));
        check("dbz_at_accept", 32'(div_by_zero), 32'(z));
        if (lat > 0) begin
            check("quotient_held_in_run", 32'(quotient), 32'(prev_q));
            check("remainder_held_in_run", 32'(remainder), 32'(prev_r));
        end
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare.
    task automatic finish_op();
        exp_t e;
        int   sum;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", 32'(done), 32'(1));
        check("sb_depth", 32'(sb.size()), 32'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("latency", 32'(cyc), 32'(e.lat));
            check("quotient", 32'(quotient), 32'(e.q));
            check("remainder", 32'(remainder), 32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.z));
            if (!e.z) begin
                sum = int'(quotient) * int'(e.b) + int'(remainder);
                check("inv_q_times_d_plus_r", 32'(sum), 32'(e.a));
                check("inv_r_lt_d", 32'(remainder < e.b), 32'(1));
            end
            prev_q = e.q;
            prev_r = e.r;
            @(posedge clk); #1;
            check("done_single_pulse", 32'(done), 32'(0));
            check("ready_after_done", 32'(ready), 32'(1));
            check("quotient_hold", 32'(quotient), 32'(e.q));
            check("remainder_hold", 32'(remainder), 32'(e.r));
            check("dbz_hold", 32'(div_by_zero), 32'(e.z));
        end
    endtask

    // Directed steps followed by the exhaustive sweep.
    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        prev_q   = 8'h00;
        prev_r   = 4'h0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 4'h0;
        #3;
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_dbz", 32'(div_by_zero), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic operation 200/7.
        launch(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
        finish_op();

        // Back-to-back 255/15, 143/11, 5/9.
        launch(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
        finish_op();
        launch(8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 8);
        finish_op();
        launch(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8);
        finish_op();

        // Divide by zero, then a normal op clears the flag at acceptance.
        launch(8'h5A, 4'd0, 8'hFF, 4'hA, 1'b1, 0);
        finish_op();
        launch(8'd9, 4'd3, 8'd3, 4'd0, 1'b0, 8);
        finish_op();

        // Start and operand changes during RUN are ignored.
        launch(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8);
        @(posedge clk); #1;
        cyc++;
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 4'd2;
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        check("ready_low_in_run", 32'(ready), 32'(0));
        check("busy_in_run", 32'(busy), 32'(1));
        finish_op();

        // Asynchronous reset after step 4 of 250/6.
        launch(8'd250, 4'd6, 8'd41, 4'd4, 1'b0, 8);
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(ready), 32'(1));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_quotient", 32'(quotient), 32'(0));
        check("arst_remainder", 32'(remainder), 32'(0));
        check("arst_dbz", 32'(div_by_zero), 32'(0));
        sb.delete();
        prev_q = 8'h00;
        prev_r = 4'h0;
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        launch(8'd250, 4'd6, 8'd41, 4'd4, 1'b0, 8);
        finish_op();

        // Exhaustive sweep over every non-zero divisor.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                launch(a[7:0], b[3:0], 8'(a / b), 4'(a % b), 1'b0, 8);
                finish_op();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
